mem_responder: RTL and testbench

Memory-side responder for the multicycle processor's load/store and fetch accesses. The control FSM and datapath act as initiator: they present an address, a direction and store data, then wait for this block's completion pulse before advancing state. It holds a word-addressed 16-bit memory array and inserts a programmable number of wait states, so the processor's control sequence is independent of memory latency.

---
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor's memory initiator and mem_responder.
// Latency: none (wires only).
// Backpressure: initiator holds req_valid until it sees req_ready at a clock edge.
// Ports: req_valid/req_wr/req_addr/req_wdata (initiator -> responder),
//        req_ready/rsp_valid/rsp_rdata/rsp_err (responder -> initiator).
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a programmable number of wait states.
// Latency: accept at edge E, one-cycle rsp_valid pulse in cycle E+WAIT_CYCLES..E+WAIT_CYCLES+1.
// Backpressure: req_ready is high only in IDLE; one request in flight, next accept at E+WAIT_CYCLES+2.
// Ports: CLK, reset (async, active-low), bus (slave side of mem_responder_if).
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                  req_ready;
  logic                  accept;
  logic                  do_access;
  logic                  acc_wr;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic                  mem_we;

  // Gated by reset so req_ready drops the instant reset goes low.
  assign req_ready = (state_q == ST_IDLE) && reset;
  assign accept    = bus.req_valid && req_ready;

  // With zero wait states the access happens on the accept edge itself, so it
  // must use the live request; otherwise it uses the copy latched at accept.
  assign acc_wr    = (state_q == ST_IDLE) ? bus.req_wr    : wr_q;
  assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

  // Full-width range check: any set bit above the array index is out of range.
  assign in_range = ((acc_addr >> DEPTH_LOG2) == '0);
  assign mem_idx  = acc_addr[DEPTH_LOG2-1:0];
  assign mem_we   = do_access && acc_wr && in_range;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access) begin
      if (in_range) begin
        err_d = 1'b0;
        // A store keeps the last load data visible.
        if (!acc_wr) begin
          rdata_d = mem[mem_idx];
        end
      end else begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a reset forces state to IDLE, which blocks
  // any pending write from reaching this port.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_idx] <= acc_wdata;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with 0.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

  logic        t_wr;
  logic [15:0] t_addr;
  logic [15:0] t_wdata;
  logic        v1;
  logic        v0;

  assign bus1.req_valid = v1;
  assign bus1.req_wr    = t_wr;
  assign bus1.req_addr  = t_addr;
  assign bus1.req_wdata = t_wdata;
  assign bus0.req_valid = v0;
  assign bus0.req_wr    = t_wr;
  assign bus0.req_addr  = t_addr;
  assign bus0.req_wdata = t_wdata;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // sel=1 selects the zero-wait-state instance.
  function automatic logic rdy(input bit sel);
    return sel ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic logic rv(input bit sel);
    return sel ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction
  function automatic logic [15:0] rd(input bit sel);
    return sel ? bus0.rsp_rdata : bus1.rsp_rdata;
  endfunction
  function automatic logic er(input bit sel);
    return sel ? bus0.rsp_err : bus1.rsp_err;
  endfunction

  // One request; request inputs are scrambled right after acceptance so the
  // response proves the latched values were used.
  task automatic do_req(input bit sel, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    bit got;
    int k;
    @(posedge clk); #2;
    t_wr = wr; t_addr = addr; t_wdata = wdata;
    if (sel) v0 = 1'b1; else v1 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy(sel)) got = 1;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    t_wr = ~wr; t_addr = ~addr; t_wdata = ~wdata;
    got = 0; k = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rv(sel)) begin got = 1; k = i; end
    end
    if (!got) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    check("rsp_latency", k, exp_lat);
    check("rsp_rdata", {16'h0, rd(sel)}, {16'h0, exp_rd});
    check("rsp_err", {31'h0, er(sel)}, {31'h0, exp_err});
    check("ready_in_resp", {31'h0, rdy(sel)}, 0);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, rv(sel)}, 0);
    check("ready_after_resp", {31'h0, rdy(sel)}, 1);
    check("err_cleared", {31'h0, er(sel)}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n_acc;
    int n_rsp;
    int low_cnt;
    int acc_cyc [4];
    logic [15:0] rsp_dat [4];
    int pulses;
    bit got;
    logic [15:0] exp_bb [4];

    exp_bb[0] = 16'hA001; exp_bb[1] = 16'hA002; exp_bb[2] = 16'hA003; exp_bb[3] = 16'hA004;
    rst_n = 1'b0; v1 = 1'b0; v0 = 1'b0; t_wr = 1'b0; t_addr = '0; t_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus1.req_ready}, 0);
    check("rst_rsp_valid", {31'h0, bus1.rsp_valid}, 0);
    check("rst_rdata", {16'h0, bus1.rsp_rdata}, 0);
    check("rst_err", {31'h0, bus1.rsp_err}, 0);
    check("rst_ready0", {31'h0, bus0.req_ready}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'h0, bus1.req_ready}, 1);

    // Store then load; store leaves rdata at its reset value.
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2);
    // Out-of-range accesses.
    do_req(0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 2);
    do_req(0, 1'b1, 16'h0000, 16'h7777, 16'h0000, 1'b0, 2);
    do_req(0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1, 2);
    do_req(0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 1'b0, 2);
    // Preload for back-to-back loads.
    do_req(0, 1'b1, 16'h0001, 16'hA001, 16'h7777, 1'b0, 2);
    do_req(0, 1'b1, 16'h0002, 16'hA002, 16'h7777, 1'b0, 2);
    do_req(0, 1'b1, 16'h0003, 16'hA003, 16'h7777, 1'b0, 2);
    do_req(0, 1'b1, 16'h0004, 16'hA004, 16'h7777, 1'b0, 2);

    // req_valid held high across four loads.
    @(posedge clk); #2;
    t_wr = 1'b0; t_addr = 16'h0001; v1 = 1'b1;
    n_acc = 0; n_rsp = 0; low_cnt = 0;
    for (int i = 0; i < 60 && n_rsp < 4; i++) begin
      @(negedge clk);
      got = 0;
      if (bus1.rsp_valid && n_rsp < 4) begin
        rsp_dat[n_rsp] = bus1.rsp_rdata;
        n_rsp++;
      end
      if (n_acc >= 1 && n_acc <= 3 && !bus1.req_ready) low_cnt++;
      if (v1 && bus1.req_ready && n_acc < 4) begin
        acc_cyc[n_acc] = cyc + 1;
        got = 1;
      end
      @(posedge clk); #2;
      if (got) begin
        n_acc++;
        if (n_acc < 4) t_addr = 16'(n_acc + 1);
        else v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    check("bb_accepts", n_acc, 4);
    check("bb_responses", n_rsp, 4);
    if (n_acc == 4) begin
      for (int i = 1; i < 4; i++) check("bb_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    end
    if (n_rsp == 4) begin
      for (int i = 0; i < 4; i++) check("bb_rdata", {16'h0, rsp_dat[i]}, {16'h0, exp_bb[i]});
    end
    check("bb_ready_low_cycles", low_cnt, 9);

    // Reset during the wait states aborts a store.
    do_req(0, 1'b1, 16'h0020, 16'h1111, 16'hA004, 1'b0, 2);
    @(posedge clk); #2;
    t_wr = 1'b1; t_addr = 16'h0020; t_wdata = 16'h5555; v1 = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus1.req_ready) got = 1;
    end
    check("abort_accept_seen", {31'h0, got}, 1);
    @(posedge clk); #1;
    v1 = 1'b0;
    #1 rst_n = 1'b0;
    pulses = 0;
    @(negedge clk);
    check("abort_ready_in_reset", {31'h0, bus1.req_ready}, 0);
    if (bus1.rsp_valid) pulses++;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_in_reset2", {31'h0, bus1.req_ready}, 0);
    if (bus1.rsp_valid) pulses++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid) pulses++;
    end
    check("abort_no_rsp", pulses, 0);
    check("abort_ready_after", {31'h0, bus1.req_ready}, 1);
    do_req(0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 2);

    // High address bits must not wrap onto 0x0010.
    do_req(0, 1'b0, 16'h8010, 16'h0000, 16'h0000, 1'b1, 2);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2);

    // Zero wait states.
    do_req(1, 1'b1, 16'h0003, 16'h00FF, 16'h0000, 1'b0, 0);
    do_req(1, 1'b0, 16'h0003, 16'h0000, 16'h00FF, 1'b0, 0);
    do_req(1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 0);
    do_req(1, 1'b0, 16'h0003, 16'h0000, 16'h00FF, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
